// File: rtl/exec_unit_mc.sv
// exec_unit_mc: multi-cycle execute stage with a valid/ready handshake on both sides.
// Muxes operand A (register/PC) and B (register/immediate/upper immediate), runs
// single-cycle ALU ops in one cycle and, when EXEC_MULDIV_EN is defined, iterative
// radix-2 multiply/divide in XLEN steps. Without EXEC_MULDIV_EN, codes 1010-1111
// execute as add and busy is tied low.
module exec_unit_mc #(
    parameter int XLEN  = 32,
    parameter int UPI_W = XLEN - 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  pc,
    input  logic [UPI_W-1:0] upi,
    input  logic             alu_src_a,
    input  logic [1:0]       alu_src_b,
    input  logic [3:0]       alu_ctrl,
    input  logic [2:0]       func3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic             zero,
    output logic             busy
);
    localparam int SH_W = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t          state_reg, state_next;
    logic [XLEN-1:0] op_a, op_b, alu_out, result_reg;
    logic [SH_W-1:0] shamt;
    logic            zero_reg, br_taken, accept, is_md, lt_s, lt_u;

    // Operand selection
    always_comb begin
        op_a = alu_src_a ? pc : a;
        case (alu_src_b)
            2'b01:   op_b = imm;
            2'b10:   op_b = {upi, 12'b0};
            default: op_b = b;
        endcase
    end

    assign shamt = op_b[SH_W-1:0];
    assign lt_s  = $signed(op_a) < $signed(op_b);
    assign lt_u  = op_a < op_b;

    // Single-cycle ALU; anything not listed (including disabled mul/div codes) is add
    always_comb begin
        alu_out = op_a + op_b;
        case (alu_ctrl)
            4'b0110: alu_out = op_a - op_b;
            4'b0000: alu_out = op_a & op_b;
            4'b0001: alu_out = op_a | op_b;
            4'b0011: alu_out = op_a ^ op_b;
            4'b0100: alu_out = op_a << shamt;
            4'b0101: alu_out = op_a >> shamt;
            4'b0111: alu_out = $unsigned($signed(op_a) >>> shamt);
            4'b1000: alu_out = {{(XLEN-1){1'b0}}, lt_s};
            4'b1001: alu_out = {{(XLEN-1){1'b0}}, lt_u};
            default: alu_out = op_a + op_b;
        endcase
    end

    // Branch decision on the muxed operands; full-width signed compare avoids overflow errors
    always_comb begin
        br_taken = 1'b0;
        case (func3)
            3'b000:  br_taken = (op_a == op_b);
            3'b001:  br_taken = (op_a != op_b);
            3'b100:  br_taken = lt_s;
            3'b101:  br_taken = !lt_s;
            3'b110:  br_taken = lt_u;
            3'b111:  br_taken = !lt_u;
            default: br_taken = 1'b0;
        endcase
    end

    assign in_ready = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

`ifdef EXEC_MULDIV_EN
    logic [XLEN-1:0] hi_reg, lo_reg, opnd_reg, dvd_reg;
    logic [SH_W-1:0] cnt_reg;
    logic [2:0]      md_op_reg;
    logic            neg_q_reg, neg_r_reg, divz_reg;
    logic [XLEN:0]   mul_sum, div_shift, div_sub;
    logic            div_ge, md_last, a_neg, b_neg;
    logic [XLEN-1:0] div_rem, step_hi, step_lo, md_result, mag_a, mag_b;

    assign is_md   = alu_ctrl[3] & (alu_ctrl[2] | alu_ctrl[1]);
    assign md_last = (cnt_reg == SH_W'(XLEN - 1));
    assign busy    = (state_reg == CALC);

    // Signed div/rem work on magnitudes; signs are re-applied at the end
    always_comb begin
        a_neg = !alu_ctrl[0] && op_a[XLEN-1];
        b_neg = !alu_ctrl[0] && op_b[XLEN-1];
        mag_a = a_neg ? -op_a : op_a;
        mag_b = b_neg ? -op_b : op_b;
    end

    // One radix-2 step: shift-add multiply or restoring divide on the {hi,lo} pair
    always_comb begin
        mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : {(XLEN+1){1'b0}});
        div_shift = {hi_reg, lo_reg[XLEN-1]};
        div_sub   = div_shift - {1'b0, opnd_reg};
        div_ge    = div_shift >= {1'b0, opnd_reg};
        div_rem   = div_ge ? div_sub[XLEN-1:0] : div_shift[XLEN-1:0];
        if (md_op_reg[2]) begin
            step_hi = div_rem;
            step_lo = {lo_reg[XLEN-2:0], div_ge};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo_reg[XLEN-1:1]};
        end
    end

    // Final result from the last step, with divide-by-zero and sign fix-ups
    always_comb begin
        if (!md_op_reg[2])
            md_result = md_op_reg[0] ? step_hi : step_lo;
        else if (divz_reg)
            md_result = md_op_reg[1] ? dvd_reg : {XLEN{1'b1}};
        else if (md_op_reg[1])
            md_result = neg_r_reg ? -step_hi : step_hi;
        else
            md_result = neg_q_reg ? -step_lo : step_lo;
    end

    // Iteration registers: load on accept, step every CALC cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_reg    <= '0;
            lo_reg    <= '0;
            opnd_reg  <= '0;
            dvd_reg   <= '0;
            cnt_reg   <= '0;
            md_op_reg <= '0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            divz_reg  <= 1'b0;
        end else if (accept && is_md) begin
            cnt_reg   <= '0;
            md_op_reg <= alu_ctrl[2:0];
            hi_reg    <= '0;
            lo_reg    <= alu_ctrl[2] ? mag_a : op_b;
            opnd_reg  <= alu_ctrl[2] ? mag_b : op_a;
            dvd_reg   <= op_a;
            neg_q_reg <= a_neg ^ b_neg;
            neg_r_reg <= a_neg;
            divz_reg  <= (op_b == '0);
        end else if (state_reg == CALC) begin
            hi_reg  <= step_hi;
            lo_reg  <= step_lo;
            cnt_reg <= cnt_reg + 1'b1;
        end
    end
`else
    assign is_md = 1'b0;
    assign busy  = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = is_md ? CALC : DONE;
`ifdef EXEC_MULDIV_EN
            CALC: if (md_last) state_next = DONE;
`endif
            DONE: if (out_ready) state_next = in_valid ? (is_md ? CALC : DONE) : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Output registers: single-cycle results at accept, iterative results on the last step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg <= '0;
            zero_reg   <= 1'b0;
        end else begin
            if (accept) begin
                zero_reg <= br_taken;
                if (!is_md) result_reg <= alu_out;
            end
`ifdef EXEC_MULDIV_EN
            if ((state_reg == CALC) && md_last) result_reg <= md_result;
`endif
        end
    end

    assign out_valid = (state_reg == DONE);
    assign result    = result_reg;
    assign zero      = zero_reg;
endmodule

// File: tb/tb_exec_unit_mc.sv
// tb_exec_unit_mc: directed vectors with literal expectations plus a cycle-by-cycle
// behavioural model of the handshake and arithmetic. Honours EXEC_MULDIV_EN.
module tb_exec_unit_mc;
    localparam int XLEN  = 32;
    localparam int UPI_W = 20;
`ifdef EXEC_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif
    localparam int MD_LAT = MD ? XLEN + 1 : 1;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, zero, busy;
    logic        alu_src_a = 1'b0;
    logic [1:0]  alu_src_b = 2'b00;
    logic [3:0]  alu_ctrl = 4'b0000;
    logic [2:0]  func3 = 3'b000;
    logic [31:0] a = '0, b = '0, imm = '0, pc = '0, result;
    logic [19:0] upi = '0;
    int checks = 0, errors = 0;

    exec_unit_mc #(.XLEN(XLEN), .UPI_W(UPI_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .imm(imm), .pc(pc), .upi(upi),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .func3(func3),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    function automatic bit is_md_code(input logic [3:0] c);
        return c >= 4'b1010;
    endfunction

    function automatic logic [31:0] mux_b(input logic [1:0] sb, input logic [31:0] vb, vimm,
                                          input logic [19:0] vupi);
        if (sb == 2'b01) return vimm;
        if (sb == 2'b10) return {vupi, 12'h000};
        return vb;
    endfunction

    // Reference arithmetic straight from the operation definitions
    function automatic logic [31:0] exp_alu(input logic [3:0] c, input logic [31:0] x, y);
        logic [63:0] p;
        logic signed [31:0] sx, sy;
        logic [4:0] sh;
        sx = x; sy = y; sh = y[4:0];
        p = {32'h0, x} * {32'h0, y};
        if (!MD && is_md_code(c)) return x + y;
        case (c)
            4'b0110: return x - y;
            4'b0000: return x & y;
            4'b0001: return x | y;
            4'b0011: return x ^ y;
            4'b0100: return x << sh;
            4'b0101: return x >> sh;
            4'b0111: return $unsigned(sx >>> sh);
            4'b1000: return (sx < sy) ? 32'd1 : 32'd0;
            4'b1001: return (x < y) ? 32'd1 : 32'd0;
            4'b1010: return p[31:0];
            4'b1011: return p[63:32];
            4'b1100: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                return $unsigned(sx / sy);
            end
            4'b1101: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            4'b1110: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                return $unsigned(sx % sy);
            end
            4'b1111: return (y == 0) ? x : x % y;
            default: return x + y;
        endcase
    endfunction

    function automatic logic exp_zero(input logic [2:0] f, input logic [31:0] x, y);
        logic signed [31:0] sx, sy;
        sx = x; sy = y;
        case (f)
            3'b000: return x == y;
            3'b001: return x != y;
            3'b100: return sx < sy;
            3'b101: return sx >= sy;
            3'b110: return x < y;
            3'b111: return x >= y;
            default: return 1'b0;
        endcase
    endfunction

    // Behavioural model: one op slot with a countdown to valid; checked every cycle
    initial begin : compare
        bit pend;
        int wait_n;
        logic [31:0] m_res, ma, mb;
        logic m_zero, ev, eb, er;
        pend = 0; wait_n = 0; m_res = '0; m_zero = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk1("rst_out_valid", out_valid, 1'b0);
                chk1("rst_busy", busy, 1'b0);
                chk1("rst_zero", zero, 1'b0);
                chk("rst_result", result, 32'h0);
                pend = 0; wait_n = 0;
            end else begin
                ev = pend && (wait_n == 0);
                eb = MD && pend && (wait_n > 0);
                er = !pend || (ev && out_ready);
                chk1("m_out_valid", out_valid, ev);
                chk1("m_busy", busy, eb);
                chk1("m_in_ready", in_ready, er);
                if (ev) begin
                    chk("m_result", result, m_res);
                    chk1("m_zero", zero, m_zero);
                end
                if (pend && wait_n > 0) wait_n--;
                if (ev && out_ready) pend = 0;
                if (in_valid && er) begin
                    ma = alu_src_a ? pc : a;
                    mb = mux_b(alu_src_b, b, imm, upi);
                    m_res  = exp_alu(alu_ctrl, ma, mb);
                    m_zero = exp_zero(func3, ma, mb);
                    pend   = 1;
                    wait_n = (MD && is_md_code(alu_ctrl)) ? XLEN : 0;
                end
            end
        end
    end

    task automatic drive(input logic sa, input logic [1:0] sb, input logic [3:0] c, input logic [2:0] f3,
                         input logic [31:0] va, vb, vimm, vpc, input logic [19:0] vupi);
        alu_src_a = sa; alu_src_b = sb; alu_ctrl = c; func3 = f3;
        a = va; b = vb; imm = vimm; pc = vpc; upi = vupi;
        in_valid = 1'b1;
    endtask

    task automatic wait_accept(input string name);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) return;
        end
        checks++; errors++;
        $display("FAIL %s_accept: in_ready never seen in 200 cycles, required within 200", name);
    endtask

    task automatic wait_valid(input string name, output int lat);
        lat = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL %s_valid: out_valid never seen in 200 cycles, required within 200", name);
    endtask

    task automatic run_op(input string name, input logic sa, input logic [1:0] sb, input logic [3:0] c,
                          input logic [2:0] f3, input logic [31:0] va, vb, vimm, vpc,
                          input logic [19:0] vupi, input bit lit_en, input logic [31:0] lit_res,
                          input logic lit_zero, input int lit_lat);
        int lat;
        @(posedge clk); #1;
        drive(sa, sb, c, f3, va, vb, vimm, vpc, vupi);
        wait_accept(name);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (lit_en) chk1({name, "_busy"}, busy, lit_lat > 1);
        wait_valid(name, lat);
        if (lit_en) begin
            chk({name, "_lat"}, lat, lit_lat);
            chk({name, "_res"}, result, lit_res);
            chk1({name, "_zero"}, zero, lit_zero);
        end
        $display("op %-10s ctrl=%b f3=%b result=0x%08h zero=%b latency=%0d", name, c, f3, result, zero, lat);
    endtask

    logic [31:0] va_t [4] = '{32'h0000_0007, 32'h8000_0000, 32'hFFFF_FFF9, 32'h1234_5678};
    logic [31:0] vb_t [4] = '{32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0025};

    initial begin : main
        int lat;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run_op("add_imm", 1'b0, 2'b01, 4'b0010, 3'b000, 32'd5, 32'd0, 32'hFFFF_FFFD, 32'd0, 20'd0,
               1, 32'd2, 1'b0, 1);
        run_op("blt_s", 1'b0, 2'b00, 4'b0010, 3'b100, 32'h8000_0000, 32'd1, 32'd0, 32'd0, 20'd0,
               1, 32'h8000_0001, 1'b1, 1);
        run_op("blt_u", 1'b0, 2'b00, 4'b0010, 3'b110, 32'h8000_0000, 32'd1, 32'd0, 32'd0, 20'd0,
               1, 32'h8000_0001, 1'b0, 1);
        run_op("blt_ovf", 1'b0, 2'b00, 4'b0010, 3'b100, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'd0, 20'd0,
               1, 32'hFFFF_FFFF, 1'b0, 1);
        run_op("auipc", 1'b1, 2'b10, 4'b0010, 3'b001, 32'd0, 32'd0, 32'd0, 32'h100, 20'h12345,
               1, 32'h1234_5100, 1'b1, 1);
        run_op("sra", 1'b0, 2'b00, 4'b0111, 3'b000, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 20'd0,
               1, 32'hF800_0000, 1'b0, 1);
        run_op("srl", 1'b0, 2'b00, 4'b0101, 3'b000, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 20'd0,
               1, 32'h0800_0000, 1'b0, 1);
        run_op("mul", 1'b0, 2'b00, 4'b1010, 3'b001, 32'hFFFF_FFF9, 32'd6, 32'd0, 32'd0, 20'd0,
               1, MD ? 32'hFFFF_FFD6 : 32'hFFFF_FFFF, 1'b1, MD_LAT);
        run_op("div_by0", 1'b0, 2'b00, 4'b1100, 3'b000, 32'd7, 32'd0, 32'd0, 32'd0, 20'd0,
               1, MD ? 32'hFFFF_FFFF : 32'd7, 1'b0, MD_LAT);
        run_op("rem_by0", 1'b0, 2'b00, 4'b1110, 3'b000, 32'd7, 32'd0, 32'd0, 32'd0, 20'd0,
               1, 32'd7, 1'b0, MD_LAT);
        run_op("div_ovf", 1'b0, 2'b00, 4'b1100, 3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 20'd0,
               1, MD ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b0, MD_LAT);
        run_op("rem_neg", 1'b0, 2'b00, 4'b1110, 3'b101, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 20'd0,
               1, MD ? 32'hFFFF_FFFF : 32'hFFFF_FFFB, 1'b0, MD_LAT);

        // Sweep every opcode over a few operand pairs, source selects and conditions
        for (int c = 0; c < 16; c++) begin
            for (int k = 0; k < 4; k++) begin
                run_op("sweep", k[0], 2'(k), 4'(c), 3'(c + k), va_t[k], vb_t[k], va_t[(k + 1) % 4],
                       32'h0000_1000 + 32'(k), 20'(32'h00ABC + 32'(c)), 0, 32'd0, 1'b0, 0);
            end
        end

        // Backpressure: result held and new op ignored while out_ready is low
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(1'b0, 2'b00, 4'b0010, 3'b000, 32'd100, 32'd23, 32'd0, 32'd0, 20'd0);
        wait_accept("bp_a");
        @(posedge clk); #1;
        drive(1'b0, 2'b00, 4'b0110, 3'b001, 32'd50, 32'd8, 32'd0, 32'd0, 20'd0);
        wait_valid("bp_a", lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_res", result, 32'd123);
            chk1("bp_hold_valid", out_valid, 1'b1);
            chk1("bp_in_ready", in_ready, 1'b0);
        end
        $display("op %-10s ctrl=0010 result=0x%08h held 5 cycles", "bp_a", result);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_accept("bp_b");
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid("bp_b", lat);
        chk("bp_b_res", result, 32'd42);
        chk1("bp_b_zero", zero, 1'b1);
        $display("op %-10s ctrl=0110 result=0x%08h zero=%b", "bp_b", result, zero);

        // Asynchronous reset in the middle of an operation
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(1'b0, 2'b00, 4'b1010, 3'b001, 32'hFFFF_FFF9, 32'd6, 32'd0, 32'd0, 20'd0);
        wait_accept("rst_mid");
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk1("rst_mid_valid", out_valid, 1'b0);
        chk1("rst_mid_busy", busy, 1'b0);
        chk1("rst_mid_zero", zero, 1'b0);
        chk("rst_mid_res", result, 32'h0);
        $display("op %-10s reset asserted mid-operation, result=0x%08h", "rst_mid", result);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        run_op("post_rst", 1'b0, 2'b00, 4'b1010, 3'b001, 32'hFFFF_FFF9, 32'd6, 32'd0, 32'd0, 20'd0,
               1, MD ? 32'hFFFF_FFD6 : 32'hFFFF_FFFF, 1'b1, MD_LAT);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation still running at 2 ms, required to finish earlier");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end
endmodule
